subneg_datapath: RTL and testbench

Execution-side responder for the SUBNEG step controller. It receives one-step commands from the control FSM:
- fetch operand 1
- fetch operand 2
- write the result
- update the PC

It performs the required memory transactions over a req/ack memory port, holds PC/op1/op2/neg, and returns a one-cycle step_done so the controller advances. Instruction format: three consecutive words A, B, C at pc. Semantics: mem[B] = mem[B] - mem[A]; if the result is negative, pc = C, else pc = pc+3.

---
 rtl/subneg_pkg.sv | 23 ++
 rtl/subneg_datapath.sv | 138 +++++++++++++
 tb/tb_subneg_datapath.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/subneg_pkg.sv
// Shared types for the SUBNEG step controller and its datapath responder.
package subneg_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_PTR,
    ST_RD_OPND,
    ST_WR_RES,
    ST_RD_TGT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    STEP_OP1,
    STEP_OP2,
    STEP_MEM,
    STEP_PC
  } step_e;

endpackage

// File: rtl/subneg_datapath.sv
// SUBNEG datapath: runs one controller step (op1/op2 fetch, result write, PC update) over a req/ack port.
// Latency: 1 + accesses*(1 + ack wait cycles) from command sample to step_done; commands ignored while busy.
module subneg_datapath
  import subneg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_op1,
  input  logic          step_op2,
  input  logic          step_mem,
  input  logic          step_pc,
  input  logic          br_take,
  output logic          step_done,
  output logic          busy,
  output logic          neg,
  output logic [AW-1:0] pc,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state, state_nxt;
  step_e         step_sel;
  logic          step_vld;
  logic          xfer;
  logic          cur_op2;
  logic [DW-1:0] op1, op2;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] diff;

  assign xfer = mem_req && mem_ack;
  assign diff = op2 - op1;

  // Fixed priority when several commands arrive together: op1 > op2 > mem > pc.
  always_comb begin
    step_vld = step_op1 | step_op2 | step_mem | step_pc;
    step_sel = STEP_PC;
    if (step_op1)      step_sel = STEP_OP1;
    else if (step_op2) step_sel = STEP_OP2;
    else if (step_mem) step_sel = STEP_MEM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (step_vld) begin
          case (step_sel)
            STEP_OP1, STEP_OP2: state_nxt = ST_RD_PTR;
            STEP_MEM:           state_nxt = ST_WR_RES;
            default:            state_nxt = br_take ? ST_RD_TGT : ST_DONE;
          endcase
        end
      end
      ST_RD_PTR:  if (xfer) state_nxt = ST_RD_OPND;
      ST_RD_OPND: if (xfer) state_nxt = ST_DONE;
      ST_WR_RES:  if (xfer) state_nxt = ST_DONE;
      ST_RD_TGT:  if (xfer) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    step_done = (state == ST_DONE);
    mem_we    = (state == ST_WR_RES);
    mem_req   = (state == ST_RD_PTR) || (state == ST_RD_OPND) ||
                (state == ST_WR_RES) || (state == ST_RD_TGT);
  end

  // Address/data only move on command accept or on an ack edge, so they stay stable while req waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= AW'(RESET_PC);
      op1       <= '0;
      op2       <= '0;
      b_addr    <= '0;
      neg       <= 1'b0;
      cur_op2   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_vld) begin
            case (step_sel)
              STEP_OP1: begin
                mem_addr <= pc;
                cur_op2  <= 1'b0;
              end
              STEP_OP2: begin
                mem_addr <= pc + AW'(1);
                cur_op2  <= 1'b1;
              end
              STEP_MEM: begin
                mem_addr  <= b_addr;
                mem_wdata <= diff;
              end
              default: begin
                if (br_take) mem_addr <= pc + AW'(2);
                else         pc       <= pc + AW'(3);
              end
            endcase
          end
        end
        ST_RD_PTR: begin
          if (xfer) begin
            mem_addr <= mem_rdata[AW-1:0];
            if (cur_op2) b_addr <= mem_rdata[AW-1:0];
          end
        end
        ST_RD_OPND: begin
          if (xfer) begin
            if (cur_op2) op2 <= mem_rdata;
            else         op1 <= mem_rdata;
          end
        end
        ST_WR_RES: if (xfer) neg <= mem_wdata[DW-1];
        ST_RD_TGT: if (xfer) pc  <= mem_rdata[AW-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subneg_datapath.sv
// Bench for subneg_datapath: memory model with programmable ack delay and a transaction scoreboard.
module tb_subneg_datapath;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } xact_t;

  logic        clk, rst;
  logic        step_op1, step_op2, step_mem, step_pc, br_take;
  logic        step_done, busy, neg;
  logic [15:0] pc;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [0:65535];
  int          ack_dly, wait_cnt;
  xact_t       sbq[$];
  int          n_cmp, n_err;

  logic [15:0] m_pc, m_op1, m_op2, m_b;
  logic        m_neg;

  subneg_datapath #(.DW(16), .AW(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .step_op1(step_op1), .step_op2(step_op2), .step_mem(step_mem), .step_pc(step_pc),
    .br_take(br_take), .step_done(step_done), .busy(busy), .neg(neg), .pc(pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (wait_cnt == ack_dly);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every cycle a request is up it must match the head of the scoreboard; pop on the ack cycle.
  always @(negedge clk) begin
    if (mem_req) begin
      if (sbq.size() == 0) chk("unexpected_req", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      else begin
        chk("req_we", {31'h0, mem_we}, {31'h0, sbq[0].we});
        chk("req_addr", {16'h0, mem_addr}, {16'h0, sbq[0].addr});
        if (sbq[0].we) chk("req_wdata", {16'h0, mem_wdata}, {16'h0, sbq[0].wdata});
        if (mem_ack) void'(sbq.pop_front());
      end
    end
  end

  task automatic push_rd(input logic [15:0] a);
    xact_t x;
    x.we = 1'b0; x.addr = a; x.wdata = 16'h0;
    sbq.push_back(x);
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_op1 = 16'h0; m_op2 = 16'h0; m_b = 16'h0; m_neg = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mask bit0=op1 bit1=op2 bit2=mem bit3=pc; glitch pulses step_pc while the step is busy.
  task automatic do_step(input string tag, input logic [3:0] mask, input logic br,
                         input int dly, input bit glitch);
    int nacc, n, exp_lat;
    logic [15:0] ptr;
    xact_t x;
    ack_dly = dly;
    if (mask[0]) begin
      ptr = mem[m_pc]; push_rd(m_pc); push_rd(ptr); m_op1 = mem[ptr]; nacc = 2;
    end else if (mask[1]) begin
      ptr = mem[m_pc + 16'd1]; push_rd(m_pc + 16'd1); push_rd(ptr);
      m_b = ptr; m_op2 = mem[ptr]; nacc = 2;
    end else if (mask[2]) begin
      x.we = 1'b1; x.addr = m_b; x.wdata = m_op2 - m_op1;
      sbq.push_back(x); m_neg = x.wdata[15]; nacc = 1;
    end else if (br) begin
      push_rd(m_pc + 16'd2); m_pc = mem[m_pc + 16'd2]; nacc = 1;
    end else begin
      m_pc = m_pc + 16'd3; nacc = 0;
    end
    exp_lat = 1 + nacc * (1 + dly);

    @(negedge clk);
    {step_pc, step_mem, step_op2, step_op1} = mask;
    br_take = br;
    @(negedge clk);
    {step_pc, step_mem, step_op2, step_op1} = 4'b0;
    br_take = 1'b0;
    n = 1;
    while (!step_done && n < 64) begin
      if (glitch && n == 1) begin
        step_pc = 1'b1; step_op1 = 1'b1;
      end
      @(negedge clk);
      step_pc = 1'b0; step_op1 = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'h0, step_done}, 32'h0);
    chk({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    chk({tag, "_pc"}, {16'h0, pc}, {16'h0, m_pc});
    chk({tag, "_neg"}, {31'h0, neg}, {31'h0, m_neg});
    chk({tag, "_sb_drained"}, sbq.size(), 0);
  endtask

  initial begin
    int n;
    n_cmp = 0; n_err = 0; ack_dly = 0;
    rst = 1'b1;
    {step_op1, step_op2, step_mem, step_pc, br_take} = 5'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    model_reset();
    mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd6; mem[10] = 16'd5; mem[11] = 16'd3;

    repeat (2) @(negedge clk);
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, step_done}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
    chk("rst_neg", {31'h0, neg}, 32'h0);
    rst = 1'b0;

    do_step("p1_op1", 4'b0001, 1'b0, 0, 1'b0);
    do_step("p1_op2", 4'b0010, 1'b0, 0, 1'b0);
    do_step("p1_mem", 4'b0100, 1'b0, 0, 1'b0);
    chk("p1_mem_result", {16'h0, mem[11]}, 32'hFFFE);
    do_step("p1_br", 4'b1000, 1'b1, 0, 1'b0);

    reset_dut();
    mem[10] = 16'd1; mem[11] = 16'd3;
    do_step("p2_op1", 4'b0001, 1'b0, 0, 1'b0);
    do_step("p2_op2", 4'b0010, 1'b0, 0, 1'b0);
    do_step("p2_mem", 4'b0100, 1'b0, 0, 1'b0);
    do_step("p2_nobr", 4'b1000, 1'b0, 0, 1'b0);

    reset_dut();
    mem[10] = 16'd5; mem[11] = 16'd3;
    do_step("slow_op1", 4'b0001, 1'b0, 3, 1'b0);
    do_step("slow_op2", 4'b0010, 1'b0, 3, 1'b0);
    do_step("slow_mem", 4'b0100, 1'b0, 3, 1'b0);
    do_step("slow_br", 4'b1000, 1'b1, 3, 1'b0);

    do_step("prio_op1_pc", 4'b1001, 1'b1, 0, 1'b0);
    do_step("busy_ignore", 4'b0010, 1'b0, 0, 1'b1);

    mem[8] = 16'hFFFE; mem[16'hFFFF] = 16'd20; mem[20] = 16'd7;
    do_step("wrap_br", 4'b1000, 1'b1, 0, 1'b0);
    do_step("wrap_op2", 4'b0010, 1'b0, 0, 1'b0);
    do_step("wrap_nobr", 4'b1000, 1'b0, 1, 1'b0);

    // Reset while the operand read of an op1 fetch is outstanding.
    reset_dut();
    mem[0] = 16'd10; mem[10] = 16'd5; mem[1] = 16'd11; mem[11] = 16'd3;
    ack_dly = 5;
    push_rd(16'd0); push_rd(16'd10);
    @(negedge clk); step_op1 = 1'b1;
    @(negedge clk); step_op1 = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 16'd10) && n < 40) begin
      @(negedge clk); n++;
    end
    chk("mid_reach_rd_opnd", {31'h0, mem_req && mem_addr == 16'd10}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_pc", {16'h0, pc}, 32'h0);
    chk("mid_rst_done", {31'h0, step_done}, 32'h0);
    sbq.delete();
    model_reset();
    @(negedge clk); rst = 1'b0;
    do_step("post_op2", 4'b0010, 1'b0, 0, 1'b0);
    do_step("post_mem", 4'b0100, 1'b0, 0, 1'b0);
    chk("post_mem_result", {16'h0, mem[11]}, 32'h0003);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
